alu_issue_ctrl: RTL and testbench

- Driver side of the single-cycle MIPS ALU's control/operand interface.
- Accepts one ALU request at a time over a valid/ready handshake, with MIPS ALUOp, funct and two operands.
- Decodes the request to the 3-bit ALU control code and drives registered control/operands into the combinational ALU.
- Waits a programmable settle time, captures the ALU result and zero flag, and returns them over a valid/ready response handshake.

---
 rtl/alu_issue_ctrl_if.sv | 39 +++
 rtl/alu_issue_ctrl.sv | 140 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Request, ALU-drive and response signals of the ALU issue controller.
// The controller connects through the slave modport; the requester, ALU and consumer use master.
`timescale 1ns/1ps
interface alu_issue_ctrl_if #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CNT_WIDTH = 16
);
    logic                 req_valid;
    logic                 req_ready;
    logic [1:0]           req_aluop;
    logic [5:0]           req_funct;
    logic [WIDTH-1:0]     req_a;
    logic [WIDTH-1:0]     req_b;

    logic [2:0]           alu_control;
    logic [WIDTH-1:0]     alu_a;
    logic [WIDTH-1:0]     alu_b;
    logic [WIDTH-1:0]     alu_out;
    logic                 alu_zero;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [WIDTH-1:0]     rsp_result;
    logic                 rsp_zero;
    logic                 rsp_illegal;
    logic [CNT_WIDTH-1:0] op_count;

    modport slave (
        input  req_valid, req_aluop, req_funct, req_a, req_b, alu_out, alu_zero, rsp_ready,
        output req_ready, alu_control, alu_a, alu_b, rsp_valid, rsp_result, rsp_zero,
               rsp_illegal, op_count
    );

    modport master (
        output req_valid, req_aluop, req_funct, req_a, req_b, alu_out, alu_zero, rsp_ready,
        input  req_ready, alu_control, alu_a, alu_b, rsp_valid, rsp_result, rsp_zero,
               rsp_illegal, op_count
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issues one MIPS ALU operation at a time: decodes ALUOp/funct, drives registered operands into
// the combinational ALU, waits SETTLE_CYCLES, then returns the captured result over a handshake.
`timescale 1ns/1ps
module alu_issue_ctrl #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input logic              clk,
    input logic              rst_n,
    alu_issue_ctrl_if.slave  bus
);

    localparam logic [1:0] StIdle = 2'b00;
    localparam logic [1:0] StExec = 2'b01;
    localparam logic [1:0] StResp = 2'b10;

    localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES - 1);

    logic [1:0]           state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [2:0]           ctrl_q, ctrl_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic                 ill_q, ill_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 zero_q, zero_d;
    logic                 illegal_q, illegal_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    logic [2:0]           dec_ctrl;
    logic                 dec_illegal;

    // Undecodable requests still get control 000 so the ALU sees a benign AND.
    always_comb begin
        dec_ctrl    = 3'b000;
        dec_illegal = 1'b0;
        case (bus.req_aluop)
            2'b00: dec_ctrl = 3'b010;
            2'b01: dec_ctrl = 3'b110;
            2'b10: begin
                case (bus.req_funct)
                    6'b100000: dec_ctrl = 3'b010;
                    6'b100010: dec_ctrl = 3'b110;
                    6'b100100: dec_ctrl = 3'b000;
                    6'b100101: dec_ctrl = 3'b001;
                    6'b101010: dec_ctrl = 3'b111;
                    default:   dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctrl_d    = ctrl_q;
        a_d       = a_q;
        b_d       = b_q;
        ill_d     = ill_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        count_d   = count_q;
        case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    ctrl_d  = dec_ctrl;
                    a_d     = bus.req_a;
                    b_d     = bus.req_b;
                    ill_d   = dec_illegal;
                    cnt_d   = SettleLoad;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Illegal requests burn the same settle time so latency is opcode-independent.
                    if (ill_q) begin
                        result_d  = '0;
                        zero_d    = 1'b1;
                        illegal_d = 1'b1;
                    end else begin
                        result_d  = bus.alu_out;
                        zero_d    = bus.alu_zero;
                        illegal_d = 1'b0;
                    end
                    state_d = StResp;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    count_d = count_q + 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            ctrl_q    <= 3'b000;
            a_q       <= '0;
            b_q       <= '0;
            ill_q     <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctrl_q    <= ctrl_d;
            a_q       <= a_d;
            b_q       <= b_d;
            ill_q     <= ill_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
        end
    end

    assign bus.req_ready   = (state_q == StIdle);
    assign bus.rsp_valid   = (state_q == StResp);
    assign bus.alu_control = ctrl_q;
    assign bus.alu_a       = a_q;
    assign bus.alu_b       = b_q;
    assign bus.rsp_result  = result_q;
    assign bus.rsp_zero    = zero_q;
    assign bus.rsp_illegal = illegal_q;
    assign bus.op_count    = count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: three instances (default, 4-cycle settle, 2-bit counter)
// share clock and reset; a behavioural MIPS ALU sits behind each one.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.WIDTH(32), .CNT_WIDTH(16)) b0 ();
    alu_issue_ctrl_if #(.WIDTH(32), .CNT_WIDTH(16)) b1 ();
    alu_issue_ctrl_if #(.WIDTH(32), .CNT_WIDTH(2))  b2 ();

    alu_issue_ctrl #(.WIDTH(32), .SETTLE_CYCLES(1), .CNT_WIDTH(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(b0.slave));
    alu_issue_ctrl #(.WIDTH(32), .SETTLE_CYCLES(4), .CNT_WIDTH(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1.slave));
    alu_issue_ctrl #(.WIDTH(32), .SETTLE_CYCLES(1), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(b2.slave));

    function automatic logic [31:0] alu_f(input logic [2:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
        case (c)
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    assign b0.alu_out  = alu_f(b0.alu_control, b0.alu_a, b0.alu_b);
    assign b0.alu_zero = (b0.alu_out == 32'd0);
    assign b1.alu_out  = alu_f(b1.alu_control, b1.alu_a, b1.alu_b);
    assign b1.alu_zero = (b1.alu_out == 32'd0);
    assign b2.alu_out  = alu_f(b2.alu_control, b2.alu_a, b2.alu_b);
    assign b2.alu_zero = (b2.alu_out == 32'd0);

    function automatic logic rdy(input int d);
        case (d)
            0:       return b0.req_ready;
            1:       return b1.req_ready;
            default: return b2.req_ready;
        endcase
    endfunction

    // Presents one request; returns 1 ns after the accepting edge.
    task automatic send(input int d, input logic [1:0] op, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (!rdy(d) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (rdy(d) !== 1'b1) begin
            errors++;
            $display("FAIL send_ready_timeout dut%0d got %b want 1", d, rdy(d));
        end
        case (d)
            0: begin
                b0.req_aluop = op; b0.req_funct = fn; b0.req_a = a; b0.req_b = b;
                b0.req_valid = 1'b1;
            end
            1: begin
                b1.req_aluop = op; b1.req_funct = fn; b1.req_a = a; b1.req_b = b;
                b1.req_valid = 1'b1;
            end
            default: begin
                b2.req_aluop = op; b2.req_funct = fn; b2.req_a = a; b2.req_b = b;
                b2.req_valid = 1'b1;
            end
        endcase
        @(posedge clk); #1;
        b0.req_valid = 1'b0;
        b1.req_valid = 1'b0;
        b2.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (b0.req_ready !== 1'b1) begin errors++;
            $display("FAIL rst_req_ready got %b want 1", b0.req_ready); end
        checks++; if (b0.rsp_valid !== 1'b0) begin errors++;
            $display("FAIL rst_rsp_valid got %b want 0", b0.rsp_valid); end
        checks++; if (b0.alu_control !== 3'b000) begin errors++;
            $display("FAIL rst_alu_control got %b want 000", b0.alu_control); end
        checks++; if (b0.alu_a !== 32'd0 || b0.alu_b !== 32'd0) begin errors++;
            $display("FAIL rst_alu_ab got %0h/%0h want 0/0", b0.alu_a, b0.alu_b); end
        checks++; if ({b0.rsp_result, b0.rsp_zero, b0.rsp_illegal} !== 34'd0) begin errors++;
            $display("FAIL rst_rsp got %0h %b %b want 0 0 0", b0.rsp_result, b0.rsp_zero,
                     b0.rsp_illegal); end
        checks++; if (b0.op_count !== 16'd0) begin errors++;
            $display("FAIL rst_op_count got %0d want 0", b0.op_count); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_funct_add();
        b0.rsp_ready = 1'b1;
        send(0, 2'b10, 6'b100000, 32'd2, 32'd2);
        checks++; if (b0.alu_control !== 3'b010) begin errors++;
            $display("FAIL add_ctrl got %b want 010", b0.alu_control); end
        checks++; if (b0.rsp_valid !== 1'b0) begin errors++;
            $display("FAIL add_early_valid got %b want 0", b0.rsp_valid); end
        @(posedge clk); #1;
        checks++; if (b0.rsp_valid !== 1'b1) begin errors++;
            $display("FAIL add_valid got %b want 1", b0.rsp_valid); end
        checks++; if (b0.rsp_result !== 32'd4 || b0.rsp_zero !== 1'b0 || b0.rsp_illegal !== 1'b0)
        begin errors++;
            $display("FAIL add_rsp got %0d %b %b want 4 0 0", b0.rsp_result, b0.rsp_zero,
                     b0.rsp_illegal); end
        @(posedge clk); #1;
        checks++; if (b0.op_count !== 16'd1) begin errors++;
            $display("FAIL add_op_count got %0d want 1", b0.op_count); end
        checks++; if (b0.rsp_valid !== 1'b0 || b0.req_ready !== 1'b1) begin errors++;
            $display("FAIL add_idle got valid %b ready %b want 0 1", b0.rsp_valid,
                     b0.req_ready); end
    endtask

    task automatic test_sub_zero();
        send(0, 2'b01, 6'b111111, 32'd5, 32'd5);
        checks++; if (b0.alu_control !== 3'b110) begin errors++;
            $display("FAIL sub_ctrl got %b want 110", b0.alu_control); end
        @(posedge clk); #1;
        checks++; if (b0.rsp_valid !== 1'b1 || b0.rsp_result !== 32'd0 || b0.rsp_zero !== 1'b1)
        begin errors++;
            $display("FAIL sub_rsp got v%b %0d z%b want v1 0 z1", b0.rsp_valid, b0.rsp_result,
                     b0.rsp_zero); end
        @(posedge clk); #1;
        checks++; if (b0.op_count !== 16'd2) begin errors++;
            $display("FAIL sub_op_count got %0d want 2", b0.op_count); end
    endtask

    task automatic test_backpressure();
        b0.rsp_ready = 1'b0;
        send(0, 2'b10, 6'b100101, 32'd0, 32'd1);
        checks++; if (b0.alu_control !== 3'b001) begin errors++;
            $display("FAIL bp_ctrl got %b want 001", b0.alu_control); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (b0.rsp_valid !== 1'b1 || b0.rsp_result !== 32'd1) begin errors++;
                $display("FAIL bp_hold cyc%0d got v%b %0d want v1 1", i, b0.rsp_valid,
                         b0.rsp_result); end
            checks++; if (b0.req_ready !== 1'b0) begin errors++;
                $display("FAIL bp_req_ready cyc%0d got %b want 0", i, b0.req_ready); end
            if (i == 0) begin
                b0.req_aluop = 2'b00; b0.req_a = 32'd7; b0.req_b = 32'd7;
                b0.req_valid = 1'b1;
            end
        end
        checks++; if (b0.alu_a !== 32'd0 || b0.alu_control !== 3'b001) begin errors++;
            $display("FAIL bp_ignored_req got a=%0d ctrl=%b want 0 001", b0.alu_a,
                     b0.alu_control); end
        checks++; if (b0.op_count !== 16'd2) begin errors++;
            $display("FAIL bp_count_stall got %0d want 2", b0.op_count); end
        b0.req_valid = 1'b0;
        b0.rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (b0.op_count !== 16'd3 || b0.rsp_valid !== 1'b0 || b0.req_ready !== 1'b1)
        begin errors++;
            $display("FAIL bp_release got cnt %0d v%b r%b want 3 0 1", b0.op_count,
                     b0.rsp_valid, b0.req_ready); end
    endtask

    task automatic test_illegal();
        logic [1:0]  ops [2] = '{2'b11, 2'b10};
        logic [15:0] cnt_exp;
        for (int i = 0; i < 2; i++) begin
            send(0, ops[i], 6'b000000, 32'd9, 32'd9);
            checks++; if (b0.alu_control !== 3'b000 || b0.rsp_valid !== 1'b0) begin errors++;
                $display("FAIL ill%0d_exec got ctrl %b v%b want 000 0", i, b0.alu_control,
                         b0.rsp_valid); end
            @(posedge clk); #1;
            checks++;
            if (b0.rsp_valid !== 1'b1 || b0.rsp_illegal !== 1'b1 || b0.rsp_result !== 32'd0 ||
                b0.rsp_zero !== 1'b1) begin errors++;
                $display("FAIL ill%0d_rsp got v%b ill%b %0d z%b want v1 ill1 0 z1", i,
                         b0.rsp_valid, b0.rsp_illegal, b0.rsp_result, b0.rsp_zero); end
            @(posedge clk); #1;
            cnt_exp = 16'(4 + i);
            checks++; if (b0.op_count !== cnt_exp) begin errors++;
                $display("FAIL ill%0d_count got %0d want %0d", i, b0.op_count, cnt_exp); end
        end
        send(0, 2'b10, 6'b101010, 32'd3, 32'd2);
        checks++; if (b0.alu_control !== 3'b111) begin errors++;
            $display("FAIL slt_ctrl got %b want 111", b0.alu_control); end
        @(posedge clk); #1;
        checks++; if (b0.rsp_result !== 32'd0 || b0.rsp_illegal !== 1'b0 || b0.rsp_zero !== 1'b1)
        begin errors++;
            $display("FAIL slt32_rsp got %0d ill%b z%b want 0 ill0 z1", b0.rsp_result,
                     b0.rsp_illegal, b0.rsp_zero); end
        @(posedge clk); #1;
        send(0, 2'b10, 6'b101010, 32'd2, 32'd3);
        @(posedge clk); #1;
        checks++; if (b0.rsp_result !== 32'd1 || b0.rsp_zero !== 1'b0) begin errors++;
            $display("FAIL slt23_rsp got %0d z%b want 1 z0", b0.rsp_result, b0.rsp_zero); end
        @(posedge clk); #1;
        checks++; if (b0.op_count !== 16'd7) begin errors++;
            $display("FAIL slt_count got %0d want 7", b0.op_count); end
    endtask

    task automatic test_settle4();
        b1.rsp_ready = 1'b1;
        send(1, 2'b00, 6'b000000, 32'd10, 32'd20);
        for (int k = 1; k <= 3; k++) begin
            checks++; if (b1.rsp_valid !== 1'b0) begin errors++;
                $display("FAIL s4_early_valid edge+%0d got %b want 0", k - 1, b1.rsp_valid); end
            checks++;
            if (b1.alu_control !== 3'b010 || b1.alu_a !== 32'd10 || b1.alu_b !== 32'd20)
            begin errors++;
                $display("FAIL s4_stable edge+%0d got %b %0d %0d want 010 10 20", k - 1,
                         b1.alu_control, b1.alu_a, b1.alu_b); end
            @(posedge clk); #1;
        end
        checks++; if (b1.rsp_valid !== 1'b0) begin errors++;
            $display("FAIL s4_valid_edge3 got %b want 0", b1.rsp_valid); end
        @(posedge clk); #1;
        checks++; if (b1.rsp_valid !== 1'b1 || b1.rsp_result !== 32'd30) begin errors++;
            $display("FAIL s4_rsp got v%b %0d want v1 30", b1.rsp_valid, b1.rsp_result); end
        @(posedge clk); #1;
        checks++; if (b1.op_count !== 16'd1) begin errors++;
            $display("FAIL s4_count got %0d want 1", b1.op_count); end
    endtask

    task automatic test_reset_mid();
        b0.rsp_ready = 1'b1;
        send(0, 2'b00, 6'b000000, 32'd1, 32'd1);
        rst_n = 1'b0;
        #1;
        checks++; if (b0.rsp_valid !== 1'b0 || b0.req_ready !== 1'b1) begin errors++;
            $display("FAIL mid_rst_hs got v%b r%b want 0 1", b0.rsp_valid, b0.req_ready); end
        checks++; if (b0.alu_control !== 3'b000 || b0.op_count !== 16'd0) begin errors++;
            $display("FAIL mid_rst_state got ctrl %b cnt %0d want 000 0", b0.alu_control,
                     b0.op_count); end
        @(posedge clk); #3;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++; if (b0.rsp_valid !== 1'b0 || b0.op_count !== 16'd0) begin errors++;
                $display("FAIL mid_rst_no_rsp cyc%0d got v%b cnt %0d want 0 0", i,
                         b0.rsp_valid, b0.op_count); end
        end
    endtask

    task automatic test_wrap();
        logic [1:0] exp_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        b2.rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(2, 2'b00, 6'b000000, 32'(i), 32'd1);
            @(posedge clk); #1;
            @(posedge clk); #1;
            checks++; if (b2.op_count !== exp_seq[i]) begin errors++;
                $display("FAIL wrap_op%0d got %0d want %0d", i, b2.op_count, exp_seq[i]); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        b0.req_valid = 1'b0; b0.req_aluop = 2'b00; b0.req_funct = 6'd0;
        b0.req_a = 32'd0; b0.req_b = 32'd0; b0.rsp_ready = 1'b0;
        b1.req_valid = 1'b0; b1.req_aluop = 2'b00; b1.req_funct = 6'd0;
        b1.req_a = 32'd0; b1.req_b = 32'd0; b1.rsp_ready = 1'b0;
        b2.req_valid = 1'b0; b2.req_aluop = 2'b00; b2.req_funct = 6'd0;
        b2.req_a = 32'd0; b2.req_b = 32'd0; b2.rsp_ready = 1'b0;
        test_reset();
        test_funct_add();
        test_sub_zero();
        test_backpressure();
        test_illegal();
        test_settle4();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
